// File: rtl/kb_uart_pkg.sv
// Package shared by the keyboard/UART bridge files.
// Holds the TX/RX state encodings, the data width of a UART frame, the mask that
// identifies LED-command bytes, and a parity helper.
// Optional feature macro: KB_UART_PARITY_EN adds the PARITY state (even parity).
package kb_uart_pkg;

    localparam int         DATA_BITS    = 8;
    localparam logic [7:0] LED_CMD_MASK = 8'hF8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Shared by the TX and RX state machines; also exported on debug ports.
    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
`ifdef KB_UART_PARITY_EN
        S_PARITY = PARITY,
`endif
        S_STOP   = STOP
    } uart_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/kb_uart_bridge_if.sv
// Keyboard-side channel of the bridge.
//   i_keycode    keycode from kb_interface
//   i_key_valid  keycode qualifier
//   o_led_status LED state back to kb_interface {caps,num,scroll}
// Handshake: i_key_valid is a one-cycle strobe with no ready/backpressure; in the
// cycle it is high i_keycode is valid and the bridge either queues it or drops it
// (a drop is reported on the overflow flag). o_led_status is a level, not a transfer.
interface kb_uart_bridge_if;
    logic [7:0] i_keycode;
    logic       i_key_valid;
    logic [2:0] o_led_status;

    // master: kb_interface side; slave: the bridge
    modport master (output i_keycode, output i_key_valid, input  o_led_status);
    modport slave  (input  i_keycode, input  i_key_valid, output o_led_status);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy level.
//   clk, rst  clock and synchronous active-high reset
//   push      write request; accepted when not full, or when full and a pop
//             happens in the same cycle
//   pop       read request; ignored while empty
//   wdata     write data
//   rdata     head-of-queue data (valid while !empty)
//   full      level == depth
//   empty     level == 0
//   level     occupancy, ADDR_W+1 bits so a full FIFO is representable
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic              do_push;
    logic              do_pop;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            // Pointers are ADDR_W bits wide, so they wrap modulo depth.
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/kb_uart_bridge.sv
// Buffered bridge between the PS/2 keyboard interface and the host UART link.
// Keycodes are queued in a FIFO and serialised LSB first at CLKS_PER_BIT clocks
// per bit; bytes from the host whose top five bits are zero set the LED status.
// Optional feature macro: KB_UART_PARITY_EN -> even parity bit on TX and RX
// (11-bit frames); undefined -> 8N1.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   kb             keyboard channel (keycode strobe in, LED status out)
//   i_TXD          UART line from host, asynchronous, idle high
//   o_RXD          UART line to host, idle high
//   o_fifo_level   FIFO occupancy
//   o_overflow     sticky: a keycode was dropped because the FIFO was full
//   o_frame_err    one-cycle pulse: a received frame was discarded
//   o_tx_state     TX FSM state (debug)
//   o_rx_state     RX FSM state (debug)
module kb_uart_bridge
    import kb_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_ADDR_W  = 4,
    parameter logic [2:0] LED_RESET    = 3'b000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    kb_uart_bridge_if.slave      kb,
    input  logic                 i_TXD,
    output logic                 o_RXD,
    output logic [FIFO_ADDR_W:0] o_fifo_level,
    output logic                 o_overflow,
    output logic                 o_frame_err,
    output uart_state_t          o_tx_state,
    output uart_state_t          o_rx_state
);

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------ FIFO
    logic [7:0] fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       overflow_q;

    sync_fifo #(.WIDTH(8), .ADDR_W(FIFO_ADDR_W)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (kb.i_key_valid),
        .pop   (fifo_pop),
        .wdata (kb.i_keycode),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_fifo_level)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            overflow_q <= 1'b0;
        else if (kb.i_key_valid && fifo_full && !fifo_pop)
            overflow_q <= 1'b1;
    end
    assign o_overflow = overflow_q;

    // ------------------------------------------------------------ TX
    uart_state_t   tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt,   tx_cnt_n;
    logic [2:0]    tx_idx,   tx_idx_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line,  tx_line_n;
    logic          tx_load;
`ifdef KB_UART_PARITY_EN
    logic          tx_par,   tx_par_n;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
`ifdef KB_UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
`ifdef KB_UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // tx_line is registered and already holds the value of the bit being sent;
    // each transition loads the level of the next bit.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
`ifdef KB_UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        tx_load    = 1'b0;
        fifo_pop   = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                tx_load   = !fifo_empty;
            end
            S_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = BIT_LAST;
                    tx_idx_n   = '0;
                    tx_line_n  = tx_shift[0];
                end else begin
                    tx_cnt_n = tx_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = BIT_LAST;
                    if (tx_idx == IDX_LAST) begin
`ifdef KB_UART_PARITY_EN
                        tx_state_n = S_PARITY;
                        tx_line_n  = tx_par;
`else
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
`endif
                    end else begin
                        tx_idx_n   = tx_idx + 3'd1;
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CW'(1);
                end
            end
`ifdef KB_UART_PARITY_EN
            S_PARITY: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_STOP;
                    tx_cnt_n   = BIT_LAST;
                    tx_line_n  = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_IDLE;
                    tx_line_n  = 1'b1;
                    // Chain straight into the next frame: no idle gap.
                    tx_load    = !fifo_empty;
                end else begin
                    tx_cnt_n = tx_cnt - CW'(1);
                end
            end
            default: begin
                tx_state_n = S_IDLE;
                tx_line_n  = 1'b1;
            end
        endcase

        if (tx_load) begin
            fifo_pop   = 1'b1;
            tx_state_n = S_START;
            tx_cnt_n   = BIT_LAST;
            tx_shift_n = fifo_rdata;
            tx_line_n  = 1'b0;
`ifdef KB_UART_PARITY_EN
            tx_par_n   = even_parity(fifo_rdata);
`endif
        end
    end

    assign o_RXD      = tx_line;
    assign o_tx_state = tx_state;

    // ------------------------------------------------------------ RX
    logic          rx_meta, rx_sync, rx_prev;
    uart_state_t   rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt,   rx_cnt_n;
    logic [2:0]    rx_idx,   rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_done_q, rx_done_n;
    logic [7:0]    rx_byte_q, rx_byte_n;
    logic          frame_err_q, frame_err_n;
    logic [2:0]    led_q;
    logic          rx_par_ok;
`ifdef KB_UART_PARITY_EN
    logic          rx_par,   rx_par_n;
    assign rx_par_ok = (even_parity(rx_shift) == rx_par);
`else
    assign rx_par_ok = 1'b1;
`endif

    // Synchroniser flops reset to the idle (high) line level so no false
    // start edge is seen when reset releases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_TXD;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            rx_done_q   <= 1'b0;
            rx_byte_q   <= '0;
            frame_err_q <= 1'b0;
            led_q       <= LED_RESET;
`ifdef KB_UART_PARITY_EN
            rx_par      <= 1'b0;
`endif
        end else begin
            rx_state    <= rx_state_n;
            rx_cnt      <= rx_cnt_n;
            rx_idx      <= rx_idx_n;
            rx_shift    <= rx_shift_n;
            rx_done_q   <= rx_done_n;
            rx_byte_q   <= rx_byte_n;
            frame_err_q <= frame_err_n;
`ifdef KB_UART_PARITY_EN
            rx_par      <= rx_par_n;
`endif
            // Bytes with any of bits [7:3] set are not LED commands.
            if (rx_done_q && ((rx_byte_q & LED_CMD_MASK) == 8'h00))
                led_q <= rx_byte_q[2:0];
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_idx_n    = rx_idx;
        rx_shift_n  = rx_shift;
        rx_byte_n   = rx_byte_q;
        rx_done_n   = 1'b0;
        frame_err_n = 1'b0;
`ifdef KB_UART_PARITY_EN
        rx_par_n    = rx_par;
`endif
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = HALF_LAST;
                end
            end
            S_START: begin
                if (rx_cnt == '0) begin
                    // Line back high at mid start bit: a glitch, drop silently.
                    if (rx_sync) begin
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = BIT_LAST;
                        rx_idx_n   = '0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    rx_cnt_n   = BIT_LAST;
                    if (rx_idx == IDX_LAST) begin
`ifdef KB_UART_PARITY_EN
                        rx_state_n = S_PARITY;
`else
                        rx_state_n = S_STOP;
`endif
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CW'(1);
                end
            end
`ifdef KB_UART_PARITY_EN
            S_PARITY: begin
                if (rx_cnt == '0) begin
                    rx_par_n   = rx_sync;
                    rx_state_n = S_STOP;
                    rx_cnt_n   = BIT_LAST;
                end else begin
                    rx_cnt_n = rx_cnt - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (rx_cnt == '0) begin
                    // Back to IDLE at mid stop bit so an immediately following
                    // start edge is caught.
                    rx_state_n = S_IDLE;
                    if (rx_sync && rx_par_ok) begin
                        rx_done_n = 1'b1;
                        rx_byte_n = rx_shift;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CW'(1);
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    assign kb.o_led_status = led_q;
    assign o_frame_err     = frame_err_q;
    assign o_rx_state      = rx_state;

endmodule
